m_dram_arbiter: RTL

Two-hart DRAM request arbiter that sits directly downstream of each hart's `m_cpummu` DRAM port and upstream of the shared DRAM controller. It captures one-cycle load/store strobes from each hart into a per-hart request slot and serialises them onto the single DRAM port. It returns a per-hart busy, fans out read data, and publishes the current owner on `w_grant` for the LR/SC reservation logic.

---
 rtl/m_dram_arbiter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/m_dram_arbiter.sv
// ---------------------------------------------------------------------------
// m_dram_arbiter
//
// Two-hart DRAM request arbiter. Each hart's one-cycle load/store strobe is
// captured into a single-entry request slot. A small FSM serialises the slots
// onto the shared DRAM port and tracks the DRAM busy handshake.
//
// Parameters
//   AW : address width
//   DW : data width
//
// Ports
//   CLK, RST_X                 clock, asynchronous active-low reset
//   w_hN_addr/wdata/ctrl       hart N request fields (N = 0, 1)
//   w_hN_we / w_hN_le          hart N one-cycle store / load strobes
//   w_hN_busy                  hart N request outstanding (combinational)
//   w_hN_odata                 read data to hart N (fan-out of w_dram_odata)
//   w_dram_addr/wdata/ctrl     DRAM request fields, held between accesses
//   w_dram_we / w_dram_le      DRAM strobes, high only in the ISSUE cycle
//   w_dram_busy                DRAM busy
//   w_dram_odata               DRAM read data
//   w_grant                    index of the hart owning, or last owning, DRAM
//   w_err                      sticky protocol-violation flag
//
// Configuration
//   DRAM_ARB_RR_EN defined   : round-robin between the two harts on a tie.
//   DRAM_ARB_RR_EN undefined : fixed priority, hart 0 wins every tie.
// ---------------------------------------------------------------------------
module m_dram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_X,
  // hart 0
  input  logic [AW-1:0] w_h0_addr,
  input  logic [DW-1:0] w_h0_wdata,
  input  logic          w_h0_we,
  input  logic          w_h0_le,
  input  logic [2:0]    w_h0_ctrl,
  output logic          w_h0_busy,
  output logic [DW-1:0] w_h0_odata,
  // hart 1
  input  logic [AW-1:0] w_h1_addr,
  input  logic [DW-1:0] w_h1_wdata,
  input  logic          w_h1_we,
  input  logic          w_h1_le,
  input  logic [2:0]    w_h1_ctrl,
  output logic          w_h1_busy,
  output logic [DW-1:0] w_h1_odata,
  // DRAM port
  output logic [AW-1:0] w_dram_addr,
  output logic [DW-1:0] w_dram_wdata,
  output logic          w_dram_we,
  output logic          w_dram_le,
  output logic [2:0]    w_dram_ctrl,
  input  logic          w_dram_busy,
  input  logic [DW-1:0] w_dram_odata,
  // status
  output logic [31:0]   w_grant,
  output logic          w_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // Number of WAIT_HI cycles tolerated without DRAM busy before giving up.
  localparam logic [1:0] HI_LAST = 2'd3;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    hi_cnt;
  logic [1:0]    hi_cnt_nxt;
  logic          owner;
  logic          err;

  // per-hart request slots
  logic [1:0]    slot_valid;
  logic [1:0]    slot_we;
  logic [AW-1:0] slot_addr  [2];
  logic [DW-1:0] slot_wdata [2];
  logic [2:0]    slot_ctrl  [2];

  // hart inputs gathered into indexable form
  logic [1:0]    in_strb;
  logic [1:0]    in_we;
  logic [AW-1:0] in_addr  [2];
  logic [DW-1:0] in_wdata [2];
  logic [2:0]    in_ctrl  [2];

  logic          sel;
  logic          pick;
  logic          clr;
  logic          tmo;
  logic [1:0]    load;
  logic [1:0]    drop;

  assign in_strb     = {w_h1_we | w_h1_le, w_h0_we | w_h0_le};
  assign in_we       = {w_h1_we, w_h0_we};
  assign in_addr[0]  = w_h0_addr;
  assign in_addr[1]  = w_h1_addr;
  assign in_wdata[0] = w_h0_wdata;
  assign in_wdata[1] = w_h1_wdata;
  assign in_ctrl[0]  = w_h0_ctrl;
  assign in_ctrl[1]  = w_h1_ctrl;

  // A strobe is accepted only into an empty slot; otherwise it is dropped
  // and flagged. A slot being cleared this cycle still counts as occupied.
  assign load = in_strb & ~slot_valid;
  assign drop = in_strb & slot_valid;

  // -------------------------------------------------------------------------
  // Winner selection (only consulted in IDLE with at least one valid slot)
  // -------------------------------------------------------------------------
`ifdef DRAM_ARB_RR_EN
  logic last_win;

  always_comb begin
    sel = ~slot_valid[0];
    if (&slot_valid) begin
      sel = ~last_win;
    end
  end

  // Reset to hart 1 so that hart 0 takes the first tie after reset.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      last_win <= 1'b1;
    end else if (pick) begin
      last_win <= sel;
    end
  end
`else
  always_comb begin
    sel = ~slot_valid[0];
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    hi_cnt_nxt = hi_cnt;
    pick       = 1'b0;
    clr        = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: begin
        if (|slot_valid) begin
          pick      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        hi_cnt_nxt = 2'd0;
        state_nxt  = WAIT_HI;
      end
      WAIT_HI: begin
        if (w_dram_busy) begin
          state_nxt = WAIT_LO;
        end else if (hi_cnt == HI_LAST) begin
          // DRAM never acknowledged: retire the request and flag it.
          tmo       = 1'b1;
          clr       = 1'b1;
          state_nxt = IDLE;
        end else begin
          hi_cnt_nxt = hi_cnt + 2'd1;
        end
      end
      WAIT_LO: begin
        if (!w_dram_busy) begin
          clr       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control state, slot valid bits and DRAM port registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state        <= IDLE;
      hi_cnt       <= 2'd0;
      owner        <= 1'b0;
      err          <= 1'b0;
      slot_valid   <= 2'b00;
      w_dram_we    <= 1'b0;
      w_dram_le    <= 1'b0;
      w_dram_addr  <= '0;
      w_dram_wdata <= '0;
      w_dram_ctrl  <= 3'd0;
    end else begin
      state     <= state_nxt;
      hi_cnt    <= hi_cnt_nxt;
      // strobes are single-cycle: set on entry to ISSUE, dropped after it
      w_dram_we <= 1'b0;
      w_dram_le <= 1'b0;
      if (pick) begin
        owner        <= sel;
        w_dram_we    <= slot_we[sel];
        w_dram_le    <= ~slot_we[sel];
        w_dram_addr  <= slot_addr[sel];
        w_dram_wdata <= slot_wdata[sel];
        w_dram_ctrl  <= slot_ctrl[sel];
      end
      for (int h = 0; h < 2; h++) begin
        if (clr && (owner == h[0])) begin
          slot_valid[h] <= 1'b0;
        end else if (load[h]) begin
          slot_valid[h] <= 1'b1;
        end
      end
      if (tmo || (|drop)) begin
        err <= 1'b1;
      end
    end
  end

  // Slot payload: only meaningful while the matching valid bit is set.
  always_ff @(posedge CLK) begin
    for (int h = 0; h < 2; h++) begin
      if (load[h]) begin
        // a simultaneous store and load strobe is treated as a store
        slot_we[h]    <= in_we[h];
        slot_addr[h]  <= in_addr[h];
        slot_wdata[h] <= in_wdata[h];
        slot_ctrl[h]  <= in_ctrl[h];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hart-facing outputs
  // -------------------------------------------------------------------------
  assign w_h0_busy  = slot_valid[0] | w_h0_we | w_h0_le;
  assign w_h1_busy  = slot_valid[1] | w_h1_we | w_h1_le;
  assign w_h0_odata = w_dram_odata;
  assign w_h1_odata = w_dram_odata;
  assign w_grant    = {31'd0, owner};
  assign w_err      = err;

endmodule
